// File: rtl/fp16_pkg.sv
// Shared widths, constants, flag positions and FSM state encoding for the
// sequential binary16 multiplier.
package fp16_pkg;

  localparam int          EXP_W     = 5;
  localparam int          MANT_W    = 10;
  localparam int          EXP_BIAS  = 15;
  localparam logic [15:0] QNAN_HALF = 16'h7E00;
  localparam logic [4:0]  EXP_INF   = 5'h1F;
  localparam logic [3:0]  MUL_LAST  = 4'd10;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_nan(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m);
    return (e == EXP_INF) && (m != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_mul_seq_if.sv
// Operand/result handshake bundle between a producer/consumer and fp16_mul_seq.
interface fp16_mul_seq_if;
  import fp16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              sign_a_half;
  logic              sign_b_half;
  logic [EXP_W-1:0]  exp_a_half;
  logic [EXP_W-1:0]  exp_b_half;
  logic [MANT_W-1:0] mant_a_half;
  logic [MANT_W-1:0] mant_b_half;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       result_half;
  logic [3:0]        flags_half;

  modport master (
    output in_valid, sign_a_half, sign_b_half, exp_a_half, exp_b_half,
           mant_a_half, mant_b_half, out_ready,
    input  in_ready, out_valid, result_half, flags_half
  );

  modport slave (
    input  in_valid, sign_a_half, sign_b_half, exp_a_half, exp_b_half,
           mant_a_half, mant_b_half, out_ready,
    output in_ready, out_valid, result_half, flags_half
  );

endinterface

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even and binary16 packing of a left-aligned 22-bit product
// (bit 21 is the hidden one), including overflow/underflow saturation.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [6:0] i_exp,
  input  logic [21:0]       i_prod,
  output logic [15:0]       o_result,
  output logic              o_of,
  output logic              o_uf,
  output logic              o_nx
);

  logic              w_guard;
  logic              w_sticky;
  logic              w_round_up;
  logic [10:0]       w_mant_sum;
  logic signed [6:0] w_exp_fin;

  assign w_guard    = i_prod[10];
  assign w_sticky   = |i_prod[9:0];
  assign w_round_up = w_guard & (w_sticky | i_prod[11]);
  assign w_mant_sum = {1'b0, i_prod[20:11]} + {10'd0, w_round_up};
  // A rounding carry leaves the mantissa field at zero and bumps the exponent.
  assign w_exp_fin  = i_exp + $signed({6'd0, w_mant_sum[10]});

  always_comb begin
    o_result = {i_sign, w_exp_fin[4:0], w_mant_sum[9:0]};
    o_of     = 1'b0;
    o_uf     = 1'b0;
    o_nx     = w_guard | w_sticky;
    if (!i_prod[21]) begin
      o_result = {i_sign, 15'd0};
      o_nx     = 1'b0;
    end else if (w_exp_fin >= 7'sd31) begin
      o_result = {i_sign, EXP_INF, 10'd0};
      o_of     = 1'b1;
      o_nx     = 1'b1;
    end else if (w_exp_fin <= 7'sd0) begin
      o_result = {i_sign, 15'd0};
      o_uf     = 1'b1;
      o_nx     = 1'b1;
    end else begin
      o_result = {i_sign, w_exp_fin[4:0], w_mant_sum[9:0]};
    end
  end

endmodule

// File: rtl/fp16_mul_seq.sv
// Sequential binary16 multiplier: 11-step shift-add significand product,
// one normalise/round cycle, and a fast path for special operands.
module fp16_mul_seq
  import fp16_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  fp16_mul_seq_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [10:0]       r_mcand;
  logic [10:0]       r_mplier;
  logic [21:0]       r_prod;
  logic signed [6:0] r_exp;
  logic              r_sign;
  logic [15:0]       r_result;
  logic [3:0]        r_flags;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic              w_special;
  logic              w_sign;
  logic [15:0]       w_spec_result;
  logic [3:0]        w_spec_flags;
  logic [6:0]        w_exp_sum;
  logic [21:0]       w_addend;
  logic [21:0]       w_norm_prod;
  logic signed [6:0] w_norm_exp;
  logic [15:0]       w_rp_result;
  logic              w_rp_of, w_rp_uf, w_rp_nx;
  logic [3:0]        w_rp_flags;

  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  assign w_sign    = bus.sign_a_half ^ bus.sign_b_half;
  assign w_a_nan   = is_nan(bus.exp_a_half, bus.mant_a_half);
  assign w_b_nan   = is_nan(bus.exp_b_half, bus.mant_b_half);
  assign w_a_inf   = (bus.exp_a_half == EXP_INF) && (bus.mant_a_half == 10'd0);
  assign w_b_inf   = (bus.exp_b_half == EXP_INF) && (bus.mant_b_half == 10'd0);
  // Subnormals are flushed: any zero exponent counts as a signed zero.
  assign w_a_zero  = (bus.exp_a_half == 5'd0);
  assign w_b_zero  = (bus.exp_b_half == 5'd0);
  assign w_special = (bus.exp_a_half == EXP_INF) || (bus.exp_b_half == EXP_INF) ||
                     w_a_zero || w_b_zero;
  assign w_exp_sum = {2'b00, bus.exp_a_half} + {2'b00, bus.exp_b_half} - 7'(EXP_BIAS);

  // Result and flags for special operands, decided entirely at accept time.
  always_comb begin
    w_spec_result = {w_sign, 15'd0};
    w_spec_flags  = 4'h0;
    if (w_a_nan || w_b_nan) begin
      w_spec_result         = QNAN_HALF;
      w_spec_flags[FLAG_NV] = (w_a_nan && !bus.mant_a_half[9]) ||
                              (w_b_nan && !bus.mant_b_half[9]);
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_result         = QNAN_HALF;
      w_spec_flags[FLAG_NV] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_result = {w_sign, EXP_INF, 10'd0};
    end else begin
      w_spec_result = {w_sign, 15'd0};
    end
  end

  assign w_addend    = r_mplier[r_cnt] ? ({11'd0, r_mcand} << r_cnt) : 22'd0;
  assign w_norm_prod = r_prod[21] ? r_prod : {r_prod[20:0], 1'b0};
  assign w_norm_exp  = r_exp + $signed({6'd0, r_prod[21]});

  fp16_round_pack u_round_pack (
    .i_sign   (r_sign),
    .i_exp    (w_norm_exp),
    .i_prod   (w_norm_prod),
    .o_result (w_rp_result),
    .o_of     (w_rp_of),
    .o_uf     (w_rp_uf),
    .o_nx     (w_rp_nx)
  );

  // Pack rounding flags into their {NV,OF,UF,NX} positions.
  always_comb begin
    w_rp_flags          = 4'h0;
    w_rp_flags[FLAG_OF] = w_rp_of;
    w_rp_flags[FLAG_UF] = w_rp_uf;
    w_rp_flags[FLAG_NX] = w_rp_nx;
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_MUL;
               else          w_state_nxt = ST_IDLE;
      ST_MUL:  if (r_cnt == MUL_LAST) w_state_nxt = ST_NORM;
               else                   w_state_nxt = ST_MUL;
      ST_NORM: w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
               else               w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add steps, rounding and result hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= 4'd0;
      r_mcand     <= 11'd0;
      r_mplier    <= 11'd0;
      r_prod      <= 22'd0;
      r_exp       <= 7'sd0;
      r_sign      <= 1'b0;
      r_result    <= 16'h0000;
      r_flags     <= 4'h0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_special) begin
            r_result    <= w_spec_result;
            r_flags     <= w_spec_flags;
            r_out_valid <= 1'b1;
          end else if (w_accept) begin
            r_cnt    <= 4'd0;
            r_mcand  <= {1'b1, bus.mant_a_half};
            r_mplier <= {1'b1, bus.mant_b_half};
            r_prod   <= 22'd0;
            r_exp    <= $signed(w_exp_sum);
            r_sign   <= w_sign;
          end
        end
        ST_MUL: begin
          r_prod <= r_prod + w_addend;
          r_cnt  <= r_cnt + 4'd1;
        end
        ST_NORM: begin
          r_result    <= w_rp_result;
          r_flags     <= w_rp_flags;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == ST_IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.result_half = r_result;
  assign bus.flags_half  = r_flags;

endmodule

// File: tb/tb_fp16_mul_seq.sv
// Self-checking bench for fp16_mul_seq: directed corner cases, randomized
// operands against an arithmetic reference model, backpressure and reset.
module tb_fp16_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp16_mul_seq_if u_if();

  fp16_mul_seq u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if.slave)
  );

  // Exact product from the binary16 rules: multiply the significands as
  // integers, locate the leading one, round the remainder to nearest-even.
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, msb, sh, e;
    bit s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, nv, inexact;
    longint p, kept, rem, half;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    a_nan = (ea == 31) && (ma != 0); b_nan = (eb == 31) && (mb != 0);
    a_inf = (ea == 31) && (ma == 0); b_inf = (eb == 31) && (mb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    if (a_nan || b_nan) begin
      nv = (a_nan && ma < 512) || (b_nan && mb < 512);
      return {nv, 3'b000, 16'h7E00};
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 16'h7E00};
    if (a_inf || b_inf) return {4'b0000, s, 15'h7C00};
    if (a_zero || b_zero) return {4'b0000, s, 15'h0000};
    p = longint'(1024 + ma) * longint'(1024 + mb);
    msb = 0;
    for (int i = 0; i < 22; i++) if (p[i]) msb = i;
    sh   = msb - 10;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = longint'(1) << (sh - 1);
    e    = ea + eb - 15 + (msb - 20);
    inexact = (rem != 0);
    if (rem > half || (rem == half && kept[0])) kept = kept + 1;
    if (kept == 2048) begin kept = 1024; e = e + 1; end
    if (e >= 31) return {4'b0101, s, 15'h7C00};
    if (e <= 0)  return {4'b0011, s, 15'h0000};
    return {3'b000, inexact, s, e[4:0], kept[9:0]};
  endfunction

  function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) || (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    int k;
    h = 16'($urandom);
    k = $urandom_range(0, 11);
    if (k == 0)      h[14:10] = 5'h1F;
    else if (k == 1) h[14:10] = 5'd0;
    else if (k == 2) h[14:0]  = 15'd0;
    else if (k == 3) h[9:0]   = 10'h3FF;
    else             h[14:10] = 5'($urandom_range(1, 30));
    return h;
  endfunction

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    u_if.sign_a_half = a[15]; u_if.exp_a_half = a[14:10]; u_if.mant_a_half = a[9:0];
    u_if.sign_b_half = b[15]; u_if.exp_b_half = b[14:10]; u_if.mant_b_half = b[9:0];
  endtask

  // Offers one operand pair and returns the number of rising edges after the
  // accept edge until OUT_VALID is seen (-1 if the block never became ready).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int n;
    n = 0;
    while (!u_if.in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!u_if.in_ready) begin lat = -1; return; end
    set_ops(a, b);
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    set_ops(16'($urandom), 16'($urandom));
    lat = 0;
    while (!u_if.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handoff();
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
    set_ops(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", u_if.in_ready); end
    checks++; if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (u_if.result_half !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", u_if.result_half); end
    checks++; if (u_if.flags_half !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h exp=0", u_if.flags_half); end
  endtask

  task automatic test_directed();
    logic [15:0] va [8] = '{16'h3C00, 16'h4000, 16'h3C01, 16'h7BFF, 16'h0400, 16'h7C00, 16'h7D00, 16'h7E00};
    logic [15:0] vb [8] = '{16'h3C00, 16'hC200, 16'h3C01, 16'h4000, 16'h0400, 16'h0000, 16'h3C00, 16'h3C00};
    logic [15:0] vr [8] = '{16'h3C00, 16'hC600, 16'h3C02, 16'h7C00, 16'h0000, 16'h7E00, 16'h7E00, 16'h7E00};
    logic [3:0]  vf [8] = '{4'h0, 4'h0, 4'h1, 4'h5, 4'h3, 4'h8, 4'h8, 4'h0};
    int          vl [8] = '{12, 12, 12, 12, 12, 0, 0, 0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], lat);
      checks++; if (u_if.result_half !== vr[i]) begin failures++; $display("FAIL dir_result %h*%h got=%h exp=%h", va[i], vb[i], u_if.result_half, vr[i]); end
      checks++; if (u_if.flags_half !== vf[i]) begin failures++; $display("FAIL dir_flags %h*%h got=%h exp=%h", va[i], vb[i], u_if.flags_half, vf[i]); end
      checks++; if (lat != vl[i]) begin failures++; $display("FAIL dir_latency %h*%h got=%0d exp=%0d", va[i], vb[i], lat, vl[i]); end
      handoff();
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [19:0] exp_v;
    int lat, exp_lat;
    for (int i = 0; i < 200; i++) begin
      a = rand_half(); b = rand_half();
      exp_v   = ref_mul(a, b);
      exp_lat = is_special(a, b) ? 0 : 12;
      do_op(a, b, lat);
      checks++; if (u_if.result_half !== exp_v[15:0]) begin failures++; $display("FAIL rand_result %h*%h got=%h exp=%h", a, b, u_if.result_half, exp_v[15:0]); end
      checks++; if (u_if.flags_half !== exp_v[19:16]) begin failures++; $display("FAIL rand_flags %h*%h got=%h exp=%h", a, b, u_if.flags_half, exp_v[19:16]); end
      checks++; if (lat != exp_lat) begin failures++; $display("FAIL rand_latency %h*%h got=%0d exp=%0d", a, b, lat, exp_lat); end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(16'h3C00, 16'h4000, lat);
    u_if.in_valid = 1'b1;
    set_ops(16'h4400, 16'h4400);
    for (int i = 0; i < 5; i++) begin
      checks++; if (u_if.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, u_if.out_valid); end
      checks++; if (u_if.result_half !== 16'h4000) begin failures++; $display("FAIL bp_result cyc=%0d got=%h exp=4000", i, u_if.result_half); end
      checks++; if (u_if.flags_half !== 4'h0) begin failures++; $display("FAIL bp_flags cyc=%0d got=%h exp=0", i, u_if.flags_half); end
      checks++; if (u_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, u_if.in_ready); end
      @(posedge clk); #1;
    end
    u_if.in_valid = 1'b0;
    handoff();
    checks++; if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_out_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_in_ready got=%b exp=1", u_if.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    set_ops(16'h3C01, 16'h4000);
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checks++; if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mul_async_in_ready got=%b exp=1", u_if.in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++; if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mul_out_valid cyc=%0d got=%b exp=0", i, u_if.out_valid); end
      if (i == 0) begin
        checks++; if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mul_in_ready got=%b exp=1", u_if.in_ready); end
      end
    end
    do_op(16'h4000, 16'h4000, lat);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (u_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_done_out_valid got=%b exp=0", u_if.out_valid); end
    checks++; if (u_if.result_half !== 16'h0000) begin failures++; $display("FAIL rst_done_result got=%h exp=0000", u_if.result_half); end
    checks++; if (u_if.in_ready !== 1'b1) begin failures++; $display("FAIL rst_done_in_ready got=%b exp=1", u_if.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [19:0] exp_v;
    int lat;
    for (int i = 0; i < 6; i++) begin
      a = rand_half(); b = rand_half();
      exp_v = ref_mul(a, b);
      do_op(a, b, lat);
      checks++; if ({u_if.flags_half, u_if.result_half} !== exp_v) begin failures++; $display("FAIL b2b_result %h*%h got=%h exp=%h", a, b, {u_if.flags_half, u_if.result_half}, exp_v); end
      handoff();
      checks++; if ({u_if.in_ready, u_if.out_valid} !== 2'b10) begin failures++; $display("FAIL b2b_handoff got=%b exp=10", {u_if.in_ready, u_if.out_valid}); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp16_mul_seq.md
FP16_MUL_SEQ -- requirements
Module: fp16_mul_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by fp16_pkg.
REQ-002 The block SHALL use exactly one clock and reset; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 IN_VALID  in  1  operand fields below are valid.
REQ-006 IN_READY  out  1  block can accept operands; high only in IDLE.
REQ-007 SIGN_A_HALF, SIGN_B_HALF  in  1 each  operand signs, as produced by fp16_decode.
REQ-008 EXP_A_HALF, EXP_B_HALF  in  5 each  biased exponents.
REQ-009 MANT_A_HALF, MANT_B_HALF  in  10 each  stored mantissas.
REQ-010 OUT_VALID  out  1  RESULT_HALF and FLAGS_HALF are valid.
REQ-011 OUT_READY  in  1  downstream accepts the result.
REQ-012 RESULT_HALF  out  16  IEEE-754 binary16 product.
REQ-013 FLAGS_HALF  out  4  sticky-free per-result flags {NV,OF,UF,NX}.

Function
REQ-014 States SHALL be IDLE, MUL, NORM, DONE; IDLE->MUL on IN_VALID&&IN_READY for finite non-zero operands.
REQ-015 Special operands (NaN, Inf, zero, subnormal) SHALL go IDLE->DONE on the accept edge, so OUT_VALID rises 1 cycle after accept.
REQ-016 Subnormal inputs (exp=0, mant!=0) SHALL be treated as signed zero (flush-to-zero).
REQ-017 Specials: any NaN -> 16'h7E00, NV=1 only if some NaN input is signalling (mant[9]=0); Inf*0 -> 16'h7E00, NV=1; Inf*finite/Inf -> signed Inf; 0*finite -> signed zero; all other flags 0.
REQ-018 Result sign SHALL always be SIGN_A_HALF^SIGN_B_HALF except for NaN results (sign 0).
REQ-019 MUL SHALL run exactly 11 cycles, one shift-add step per cycle on 11-bit significands (hidden bit 1), producing a 22-bit product; a 4-bit counter tracks steps.
REQ-020 Exponent SHALL be computed as EXP_A+EXP_B-15 in a 7-bit signed register.
REQ-021 NORM (1 cycle): if product[21]=1, shift right 1 and exponent+1; then round-to-nearest-even on guard and sticky bits; mantissa carry-out after rounding SHALL increment the exponent.
REQ-022 Final exponent >=31 SHALL give signed Inf with OF=1, NX=1; final exponent <=0 SHALL give signed zero with UF=1, NX=1; any discarded non-zero bits set NX=1.
REQ-023 Normal-path latency: accept edge k -> OUT_VALID high after edge k+12.
REQ-024 DONE SHALL hold RESULT_HALF, FLAGS_HALF and OUT_VALID stable until OUT_READY=1; on that edge go to IDLE.
REQ-025 No new operand SHALL be accepted in the same cycle a result is handed off; IN_READY is 0 in MUL, NORM and DONE.
REQ-026 IN_VALID while not in IDLE SHALL be ignored; operand fields are captured only on the accept edge.

Reset
REQ-027 RST_N low SHALL asynchronously force state IDLE, counter 0, OUT_VALID 0, RESULT_HALF 16'h0000, FLAGS_HALF 4'h0, all datapath registers 0.
REQ-028 Reset asserted mid-MUL or in DONE SHALL abandon the operation; no result is emitted after release.
REQ-029 IN_READY SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 fp16_pkg SHALL hold EXP_W=5, MANT_W=10, EXP_BIAS=15, QNAN_HALF=16'h7E00, INF exponent 5'h1F, flag bit indices and the state enum.
REQ-031 Rounding and packing SHALL live in one combinational sub-module fp16_round_pack (inputs: sign, 7-bit exponent, normalised 22-bit product; outputs: 16-bit result, OF/UF/NX).

Verification
REQ-032 3C00*3C00 -> RESULT 3C00, FLAGS 0, OUT_VALID 12 cycles after accept.
REQ-033 4000*C200 (2 * -3) -> C600, FLAGS 0; 3C01*3C01 -> 3C02, NX=1 (RNE).
REQ-034 7BFF*4000 -> 7C00, OF=1, NX=1; 0400*0400 -> 0000, UF=1, NX=1.
REQ-035 7C00*0000 -> 7E00, NV=1, OUT_VALID 1 cycle after accept; 7D00*3C00 (sNaN) -> 7E00, NV=1.
REQ-036 OUT_READY held 0 for 5 cycles in DONE -> outputs stable and IN_READY=0 throughout; RST_N pulsed low mid-MUL -> OUT_VALID stays 0 and IN_READY=1 after release.
